// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
package pipe_ctrl_pkg;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    LU_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  // Counter preload for an n-cycle window; the first cycle is spent in RUN.
  function automatic logic [2:0] window_preload(input int n);
    return 3'(n - 1);
  endfunction
endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the pipeline and pipe_ctrl.
// stall_cnt_o is present only when PIPE_CTRL_STALL_CNT_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic              hold_risk_i;
  logic              mem_busy_i;
  logic              pc_load_o;
  logic [ADDR_W-1:0] pc_load_addr_o;
  logic              hold_pc_o;
  logic              hold_if_id_o;
  logic              hold_id_ex_o;
  logic              hold_ex_mem_o;
  logic              flush_if_id_o;
  logic              flush_id_ex_o;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
`endif

  modport master (
    input  jump_flag_i, jump_addr_i, hold_risk_i, mem_busy_i,
    output pc_load_o, pc_load_addr_o, hold_pc_o, hold_if_id_o,
           hold_id_ex_o, hold_ex_mem_o, flush_if_id_o, flush_id_ex_o
`ifdef PIPE_CTRL_STALL_CNT_EN
    , output stall_cnt_o
`endif
  );

  modport slave (
    output jump_flag_i, jump_addr_i, hold_risk_i, mem_busy_i,
    input  pc_load_o, pc_load_addr_o, hold_pc_o, hold_if_id_o,
           hold_id_ex_o, hold_ex_mem_o, flush_if_id_o, flush_id_ex_o
`ifdef PIPE_CTRL_STALL_CNT_EN
    , input stall_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_ctrl_seq_cnt.sv
// Loadable 3-bit down-counter for flush/stall windows; freeze overrides load and decrement.
module pipe_ctrl_seq_cnt (
  input  logic       clk,
  input  logic       arst,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  input  logic       freeze,
  output logic [2:0] cnt,
  output logic       zero
);
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= 3'd0;
    end else if (!freeze) begin
      if (load) begin
        cnt <= load_val;
      end else if (dec && cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  assign zero = (cnt == 3'd0);
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush/PC-load sequencer; Mealy outputs, pending redirect kept across memory waits.
// Optional stall-cycle counter enabled by PIPE_CTRL_STALL_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES    = 2,
  parameter int LU_STALL_CYCLES = 1
) (
  input logic         clk,
  input logic         arst,
  pipe_ctrl_if.master bus
);
  localparam logic [2:0] FL_INIT = window_preload(FLUSH_CYCLES);
  localparam logic [2:0] LU_INIT = window_preload(LU_STALL_CYCLES);

  state_t            state, state_nxt;
  logic              pend_vld, pend_vld_nxt;
  logic [ADDR_W-1:0] pend_addr, pend_addr_nxt;
  logic              cnt_load, cnt_dec, cnt_freeze, cnt_zero;
  logic [2:0]        cnt_load_val, cnt;
  logic              cnt_last;

  pipe_ctrl_seq_cnt u_cnt (
    .clk      (clk),
    .arst     (arst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .freeze   (cnt_freeze),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // The window ends on the cycle whose decrement reaches zero.
  assign cnt_last = cnt_zero || (cnt == 3'd1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= RUN;
      pend_vld  <= 1'b0;
      pend_addr <= ZERO_WORD;
    end else begin
      state     <= state_nxt;
      pend_vld  <= pend_vld_nxt;
      pend_addr <= pend_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pend_vld_nxt  = pend_vld;
    pend_addr_nxt = pend_addr;
    cnt_load      = 1'b0;
    cnt_load_val  = 3'd0;
    cnt_dec       = 1'b0;
    cnt_freeze    = 1'b0;
    case (state)
      RUN: begin
        if (bus.mem_busy_i) begin
          state_nxt = MEM_WAIT;
          if (bus.jump_flag_i) begin
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = bus.jump_addr_i;
          end
        end else if (bus.jump_flag_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = FL_INIT;
          state_nxt    = (FL_INIT != 3'd0) ? FLUSH : RUN;
        end else if (bus.hold_risk_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = LU_INIT;
          state_nxt    = (LU_INIT != 3'd0) ? LU_STALL : RUN;
        end
      end
      FLUSH, LU_STALL: begin
        if (bus.mem_busy_i) begin
          cnt_freeze = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          if (cnt_last) state_nxt = RUN;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_busy_i) begin
          // Only the first redirect counts: EX is frozen, so later ones are repeats.
          if (bus.jump_flag_i && !pend_vld) begin
            pend_vld_nxt  = 1'b1;
            pend_addr_nxt = bus.jump_addr_i;
          end
        end else if (pend_vld) begin
          pend_vld_nxt = 1'b0;
          cnt_load     = 1'b1;
          cnt_load_val = FL_INIT;
          state_nxt    = (FL_INIT != 3'd0) ? FLUSH : RUN;
        end else begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  logic              o_pc_load, o_hold_pc, o_hold_if_id, o_hold_id_ex, o_hold_ex_mem;
  logic              o_flush_if_id, o_flush_id_ex;
  logic [ADDR_W-1:0] o_pc_addr;

  always_comb begin
    o_pc_load     = 1'b0;
    o_pc_addr     = ZERO_WORD;
    o_hold_pc     = 1'b0;
    o_hold_if_id  = 1'b0;
    o_hold_id_ex  = 1'b0;
    o_hold_ex_mem = 1'b0;
    o_flush_if_id = 1'b0;
    o_flush_id_ex = 1'b0;
    if (bus.mem_busy_i) begin
      o_hold_pc     = 1'b1;
      o_hold_if_id  = 1'b1;
      o_hold_id_ex  = 1'b1;
      o_hold_ex_mem = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.jump_flag_i) begin
            o_pc_load     = 1'b1;
            o_pc_addr     = bus.jump_addr_i;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end else if (bus.hold_risk_i) begin
            o_hold_pc     = 1'b1;
            o_hold_if_id  = 1'b1;
            o_flush_id_ex = 1'b1;
          end
        end
        FLUSH: begin
          o_flush_if_id = 1'b1;
          o_flush_id_ex = 1'b1;
        end
        LU_STALL: begin
          o_hold_pc     = 1'b1;
          o_hold_if_id  = 1'b1;
          o_flush_id_ex = 1'b1;
        end
        MEM_WAIT: begin
          if (pend_vld) begin
            o_pc_load     = 1'b1;
            o_pc_addr     = pend_addr;
            o_flush_if_id = 1'b1;
            o_flush_id_ex = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_load_o      = o_pc_load;
  assign bus.pc_load_addr_o = o_pc_addr;
  assign bus.hold_pc_o      = o_hold_pc;
  assign bus.hold_if_id_o   = o_hold_if_id;
  assign bus.hold_id_ex_o   = o_hold_id_ex;
  assign bus.hold_ex_mem_o  = o_hold_ex_mem;
  assign bus.flush_if_id_o  = o_flush_if_id;
  assign bus.flush_id_ex_o  = o_flush_id_ex;

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cnt <= 32'd0;
    end else if (o_hold_pc) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
  assign bus.stall_cnt_o = stall_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal checks plus randomized traffic against a window-count model.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;
  localparam int FLC = 2;
  localparam int LUC = 3;

  localparam logic [6:0] C_HOLD = 7'b0111100;
  localparam logic [6:0] C_RED  = 7'b1000011;
  localparam logic [6:0] C_FL   = 7'b0000011;
  localparam logic [6:0] C_LU   = 7'b0110001;

  logic clk  = 1'b0;
  logic arst = 1'b1;
  pipe_ctrl_if bus();

  pipe_ctrl #(.FLUSH_CYCLES(FLC), .LU_STALL_CYCLES(LUC)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] ctl_now;
  assign ctl_now = {bus.pc_load_o, bus.hold_pc_o, bus.hold_if_id_o, bus.hold_id_ex_o,
                    bus.hold_ex_mem_o, bus.flush_if_id_o, bus.flush_id_ex_o};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ctl(input string name, input logic [6:0] exp);
    chk(name, {25'd0, ctl_now}, {25'd0, exp});
  endtask

  // Model: outstanding flush/stall cycles, memory-wait flag and pending redirect.
  int          flush_left = 0;
  int          stall_left = 0;
  bit          waiting    = 0;
  bit          pend       = 0;
  logic [31:0] pend_a     = 0;
  logic [31:0] m_stall    = 0;

  always @(negedge clk) begin : compare
    logic [6:0]  e;
    logic [31:0] ea;
    bit jf, hr, mb;
    if (arst) begin
      flush_left = 0; stall_left = 0; waiting = 0; pend = 0; pend_a = 0; m_stall = 0;
      chk_ctl("reset_ctl", 7'd0);
      chk("reset_addr", bus.pc_load_addr_o, 32'd0);
    end else begin
      e = 7'd0; ea = 32'd0;
      jf = bus.jump_flag_i; hr = bus.hold_risk_i; mb = bus.mem_busy_i;
      if (waiting) begin
        if (mb) begin
          e = C_HOLD;
          if (jf && !pend) begin pend = 1; pend_a = bus.jump_addr_i; end
        end else begin
          waiting = 0;
          if (pend) begin e = C_RED; ea = pend_a; pend = 0; flush_left = FLC - 1; end
        end
      end else if (flush_left > 0) begin
        if (mb) e = C_HOLD;
        else begin e = C_FL; flush_left--; end
      end else if (stall_left > 0) begin
        if (mb) e = C_HOLD;
        else begin e = C_LU; stall_left--; end
      end else if (mb) begin
        e = C_HOLD; waiting = 1;
        if (jf) begin pend = 1; pend_a = bus.jump_addr_i; end
      end else if (jf) begin
        e = C_RED; ea = bus.jump_addr_i; flush_left = FLC - 1;
      end else if (hr) begin
        e = C_LU; stall_left = LUC - 1;
      end
      chk_ctl("model_ctl", e);
      chk("model_addr", bus.pc_load_addr_o, ea);
`ifdef PIPE_CTRL_STALL_CNT_EN
      chk("model_stall_cnt", bus.stall_cnt_o, m_stall);
      if (e[5]) m_stall = m_stall + 32'd1;
`endif
    end
  end

  task automatic drive(input bit jf, input logic [31:0] ja, input bit hr, input bit mb);
    @(posedge clk);
    #1;
    bus.jump_flag_i = jf;
    bus.jump_addr_i = ja;
    bus.hold_risk_i = hr;
    bus.mem_busy_i  = mb;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    arst = 1'b1;
    bus.jump_flag_i = 1'b0; bus.jump_addr_i = 32'd0;
    bus.hold_risk_i = 1'b0; bus.mem_busy_i  = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  initial begin
    bus.jump_flag_i = 1'b0; bus.jump_addr_i = 32'd0;
    bus.hold_risk_i = 1'b0; bus.mem_busy_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(negedge clk);
    chk_ctl("por_ctl", 7'd0);

    // Plain redirect: one load cycle, one extra flush cycle.
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    chk_ctl("j80_c0_ctl", C_RED);
    chk("j80_c0_addr", bus.pc_load_addr_o, 32'h80);
    idle(); chk_ctl("j80_c1_ctl", C_FL);
    idle(); chk_ctl("j80_c2_ctl", 7'd0);

    // Reset while in the flush window, then redirect immediately.
    drive(1'b1, 32'h80, 1'b0, 1'b0);
    do_reset();
    @(negedge clk);
    chk_ctl("post_rst_ctl", 7'd0);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    chk_ctl("j100_ctl", C_RED);
    chk("j100_addr", bus.pc_load_addr_o, 32'h100);
    idle(); idle();

    // Load-use hazard: three-cycle bubble.
    drive(1'b0, 32'd0, 1'b1, 1'b0); chk_ctl("lu_c0", C_LU);
    idle(); chk_ctl("lu_c1", C_LU);
    idle(); chk_ctl("lu_c2", C_LU);
    idle(); chk_ctl("lu_c3", 7'd0);

    // Redirect wins over a simultaneous hazard.
    drive(1'b1, 32'h40, 1'b1, 1'b0);
    chk_ctl("jlu_c0", C_RED);
    chk("jlu_addr", bus.pc_load_addr_o, 32'h40);
    idle(); chk_ctl("jlu_c1", C_FL);
    idle(); chk_ctl("jlu_c2", 7'd0);

    // Five busy cycles with a redirect captured in the first.
    do_reset();
    drive(1'b1, 32'h200, 1'b0, 1'b1); chk_ctl("mb_c0", C_HOLD);
    for (int i = 1; i < 5; i++) begin
      drive(1'b0, 32'd0, 1'b0, 1'b1); chk_ctl("mb_hold", C_HOLD);
    end
    idle(); chk_ctl("mb_rel_ctl", C_RED);
    chk("mb_rel_addr", bus.pc_load_addr_o, 32'h200);
    idle(); chk_ctl("mb_flush", C_FL);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    idle(); idle(); idle();
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("stall_cnt_lit", bus.stall_cnt_o, 32'd5 + 32'(LUC));
`endif

    // Long wait: first redirect kept, later ones ignored.
    drive(1'b1, 32'h300, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h400, 1'b0, 1'b1);
    idle(); chk("pend_first_addr", bus.pc_load_addr_o, 32'h300);
    idle(); idle();

    // Redirect arriving mid-wait is still captured.
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    drive(1'b1, 32'h500, 1'b0, 1'b1);
    idle(); chk("pend_late_addr", bus.pc_load_addr_o, 32'h500);
    idle(); idle();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      drive(($urandom_range(3) == 0), $urandom, ($urandom_range(3) == 0),
            ($urandom_range(4) == 0));
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It turns execute-stage redirect requests, load-use hazard requests and data-memory wait requests into per-stage hold, flush and PC-load controls. A small state machine with a cycle counter sequences the multi-cycle flush and stall windows. It also latches a redirect that arrives while memory is busy, so no taken branch or jump is lost.

## Interface
- `FLUSH_CYCLES`, default 2: number of cycles `flush_if_id_o` stays asserted after a redirect (1–7).
- `LU_STALL_CYCLES`, default 1: number of bubble cycles inserted for a load-use hazard (1–7).
- `clk` input 1: core clock, rising edge.
- `arst` input 1: asynchronous reset, active-high.
- `jump_flag_i` input 1: execute stage requests a redirect (taken branch, JAL, JALR).
- `jump_addr_i` input 32: redirect target, valid when `jump_flag_i` is high.
- `hold_risk_i` input 1: execute stage reports a load-use hazard.
- `mem_busy_i` input 1: data memory is not ready; the whole pipeline must freeze.
- `pc_load_o` output 1: PC register loads `pc_load_addr_o` this cycle.
- `pc_load_addr_o` output 32: PC load target.
- `hold_pc_o` output 1: freeze the PC.
- `hold_if_id_o` output 1: freeze the IF/ID register.
- `hold_id_ex_o` output 1: freeze the ID/EX register.
- `hold_ex_mem_o` output 1: freeze the EX/MEM register.
- `flush_if_id_o` output 1: load a NOP into IF/ID.
- `flush_id_ex_o` output 1: load a NOP into ID/EX.
- `stall_cnt_o` output 32: stall-cycle counter; present only with `PIPE_CTRL_STALL_CNT_EN`.

## Operation
- States: RUN, FLUSH, LU_STALL, MEM_WAIT.
- 3-bit down-counter `cnt`. Pending-redirect register `pend_vld`/`pend_addr`.
- Input priority each cycle: `mem_busy_i`, then redirect, then `hold_risk_i`.
- **RUN**
  - `mem_busy_i` high: assert all four holds. Go to MEM_WAIT. If `jump_flag_i` is also high, capture `pend_vld=1` and `pend_addr=jump_addr_i`.
  - Else if `jump_flag_i` high: `pc_load_o=1`, `pc_load_addr_o=jump_addr_i`, `flush_if_id_o=1`, `flush_id_ex_o=1`. Set `cnt=FLUSH_CYCLES-1`. Go to FLUSH if `cnt` is nonzero, otherwise stay in RUN.
  - Else if `hold_risk_i` high: `hold_pc_o=1`, `hold_if_id_o=1`, `flush_id_ex_o=1`. Set `cnt=LU_STALL_CYCLES-1`. Go to LU_STALL if `cnt` is nonzero, otherwise stay in RUN.
  - Redirect together with `hold_risk_i`: the redirect wins and the hazard is discarded, because the hazard belongs to a younger, flushed instruction.
- **FLUSH**
  - Assert `flush_if_id_o` and `flush_id_ex_o`.
  - `jump_flag_i` and `hold_risk_i` are ignored.
  - Decrement `cnt`; leave for RUN when `cnt==0`.
  - `mem_busy_i` high: outputs are holds only, `cnt` freezes, state is kept.
- **LU_STALL**
  - Same outputs as the RUN hazard cycle.
  - Decrement `cnt`; go to RUN at 0.
  - `mem_busy_i` freezes the state exactly as in FLUSH.
- **MEM_WAIT**
  - All holds asserted; no flush.
  - `jump_flag_i` with `pend_vld==0` is captured into the pending register. When `pend_vld==1`, further redirects are ignored because the EX stage is frozen.
  - On `mem_busy_i` low:
    - `pend_vld==1`: drive the RUN redirect outputs from `pend_addr`, clear `pend_vld`, enter FLUSH with `cnt=FLUSH_CYCLES-1` (or RUN if that is 0).
    - Otherwise: return to RUN with no outputs asserted that cycle.
- Outputs not listed for a state are 0. `pc_load_addr_o` is 0 whenever `pc_load_o` is 0.

## Timing
- Outputs are combinational (Mealy) from state, counter, pending register and inputs. No input-to-output register stage.
- A redirect takes effect in the same cycle it is requested. The next cycle the PC presents the target.
- Next state, `cnt`, and the pending register update on the rising edge of `clk`.
- `arst` forces RUN, `cnt=0`, `pend_vld=0`, `pend_addr=0` and `stall_cnt_o=0` immediately, including in mid-sequence.
- Output reset values: every output is 0.
- A pending redirect survives any length of MEM_WAIT.

## Configuration
- `PIPE_CTRL_STALL_CNT_EN` defined:
  - `stall_cnt_o` exists.
  - It increments by 1 on every cycle with `hold_pc_o==1`.
  - It wraps from 0xFFFFFFFF to 0.
- Not defined: the port and the counter are absent, and all other behaviour is identical.

## Structure
- Shared package holds:
  - the state enumeration (RUN=0, FLUSH=1, LU_STALL=2, MEM_WAIT=3);
  - the 32-bit address width;
  - the zero-word constant.
- One sub-module, `pipe_ctrl_seq_cnt`: the loadable 3-bit down-counter with freeze and zero flag.
- All remaining logic stays in `pipe_ctrl`.

## Test plan
- Reset during FLUSH (`cnt=1`), then release: all outputs 0; the next `jump_flag_i` with target 0x100 gives `pc_load_o=1` and `pc_load_addr_o=0x100` in that same cycle.
- Jump to 0x80 in RUN, default params: cycle 0 `pc_load_o=1` plus both flushes; cycle 1 both flushes, `pc_load_o=0`; cycle 2 all outputs 0.
- `hold_risk_i` for 1 cycle with `LU_STALL_CYCLES=3`: `hold_pc_o`, `hold_if_id_o` and `flush_id_ex_o` are high for exactly 3 cycles.
- Simultaneous `jump_flag_i` (0x40) and `hold_risk_i`: redirect to 0x40 with flushes; no LU_STALL is entered.
- `mem_busy_i` for 5 cycles with `jump_flag_i` (0x200) in the first: holds high for 5 cycles, then `pc_load_o=1` to 0x200, then one FLUSH cycle.
- With `PIPE_CTRL_STALL_CNT_EN`: the 5-cycle busy case plus one load-use stall gives `stall_cnt_o==6`.
